// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester valid/ready bus plus transmitter parallel-input bus
// Ports (slave = arbiter side):
//   req_valid/req_data/req_par_en/req_par_type in, req_ready out  - per-requester handshake
//   tx_busy in, tx_data_valid/tx_parallel_data/tx_par_en/tx_par_type out - transmitter side
interface uart_tx_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req_valid, req_ready, req_par_en, req_par_type;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic tx_busy, tx_data_valid, tx_par_en, tx_par_type;
  logic [DATA_WIDTH-1:0] tx_parallel_data;
  modport master (
    output req_valid, req_data, req_par_en, req_par_type, tx_busy,
    input req_ready, tx_data_valid, tx_parallel_data, tx_par_en, tx_par_type
  );
  modport slave (
    input req_valid, req_data, req_par_en, req_par_type, tx_busy,
    output req_ready, tx_data_valid, tx_parallel_data, tx_par_en, tx_par_type
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ requesters
// Ports: clk, reset_n (sync, active-low); bus (slave modport: requester handshake + transmitter input);
//   grant_id = owner of current/last frame, active = not IDLE, timeout_err = busy-rise timeout pulse
module uart_tx_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ = 4,
  parameter int BUSY_TIMEOUT = 4,
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic clk,
  input  logic reset_n,
  uart_tx_arbiter_if.slave bus,
  output logic [IW-1:0] grant_id,
  output logic active,
  output logic timeout_err
);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic pen_q, pen_d, ptype_q, ptype_d;
  logic [IW-1:0] grant_q, grant_d, last_q, last_d, win;
  logic [CW-1:0] cnt_q, cnt_d;
  logic any, accept, timeout_hit;
  // Scan downward so the nearest index after last_q is written last and wins.
  always_comb begin
    win = last_q;
    any = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (bus.req_valid[IW'((int'(last_q) + k) % NUM_REQ)]) begin
        win = IW'((int'(last_q) + k) % NUM_REQ);
        any = 1'b1;
      end
  end
  // Gated by reset_n so no accept strobe escapes while reset is held.
  assign accept = reset_n && state_q == IDLE && !bus.tx_busy && any;
  assign timeout_hit = state_q == WAIT_BUSY && !bus.tx_busy && cnt_q == CW'(BUSY_TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    pen_d = pen_q;
    ptype_d = ptype_q;
    grant_d = grant_q;
    last_d = last_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = LAUNCH;
        data_d = bus.req_data[win*DATA_WIDTH +: DATA_WIDTH];
        pen_d = bus.req_par_en[win];
        ptype_d = bus.req_par_type[win];
        grant_d = win;
        last_d = win;
      end
      LAUNCH: begin
        state_d = WAIT_BUSY;
        cnt_d = '0;
      end
      WAIT_BUSY: if (bus.tx_busy) state_d = WAIT_DONE;
      else begin
        cnt_d = cnt_q + 1'b1;
        state_d = timeout_hit ? IDLE : WAIT_BUSY;
      end
      WAIT_DONE: state_d = bus.tx_busy ? WAIT_DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      state_q <= IDLE;
      data_q <= '0;
      pen_q <= 1'b0;
      ptype_q <= 1'b0;
      grant_q <= '0;
      last_q <= IW'(NUM_REQ - 1);
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      pen_q <= pen_d;
      ptype_q <= ptype_d;
      grant_q <= grant_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
    end
  assign bus.req_ready = accept ? {{(NUM_REQ-1){1'b0}}, 1'b1} << win : '0;
  assign bus.tx_data_valid = state_q == LAUNCH;
  assign bus.tx_parallel_data = data_q;
  assign bus.tx_par_en = pen_q;
  assign bus.tx_par_type = ptype_q;
  assign grant_id = grant_q;
  assign active = state_q != IDLE;
  assign timeout_err = timeout_hit;
endmodule
